// File: rtl/fifo_cmd_writer.sv
// fifo_cmd_writer: host-side writer for the external byte-wide async command FIFO.
// Buffers command bytes in a small circular queue and writes each one into the FIFO
// with programmable setup / strobe / hold / recovery timing on the active-low -W strobe.
module fifo_cmd_writer #(
   parameter int DEPTH          = 4,
   parameter int SETUP_CYCLES   = 2,
   parameter int PULSE_CYCLES   = 4,
   parameter int HOLD_CYCLES    = 2,
   parameter int RECOVER_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        fifo_nff_in,
   output logic [7:0]  fifo_d,
   output logic        fifo_nwr,
   output logic        fifo_full,
   output logic        busy,
   output logic [15:0] wr_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_RECOVER
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [1:0]      sync_q;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic [7:0]      fifo_d_q, fifo_d_d;
   logic            nwr_q, nwr_d;
   logic            busy_q, busy_d;
   logic [15:0]     wr_count_q, wr_count_d;
   logic            push, pop;

   // The second synchronizer stage is itself a flop, so fifo_full is a registered output.
   assign fifo_full = ~sync_q[1];
   assign cmd_ready = cmd_ready_q;
   assign fifo_d    = fifo_d_q;
   assign fifo_nwr  = nwr_q;
   assign busy      = busy_q;
   assign wr_count  = wr_count_q;

   assign push = cmd_valid & cmd_ready_q;

   // Next-state logic: write-cycle sequencer, queue bookkeeping and registered outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
      state_d    = state_q;
      tmr_d      = tmr_q;
      nwr_d      = nwr_q;
      fifo_d_d   = fifo_d_q;
      wr_count_d = wr_count_q;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Never start a write while the FIFO reports full.
            if ((count_q != '0) && !fifo_full) begin
               pop      = 1'b1;
               fifo_d_d = mem_q[rd_ptr_q];
               state_d  = S_SETUP;
               tmr_d    = TW'(SETUP_CYCLES - 1);
            end
         end
         S_SETUP: begin
            if (tmr_q == '0) begin
               nwr_d   = 1'b0;
               state_d = S_STROBE;
               tmr_d   = TW'(PULSE_CYCLES - 1);
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_STROBE: begin
            // A full flag rising here does not abort: the FIFO saw not-full before the write.
            if (tmr_q == '0) begin
               nwr_d      = 1'b1;
               wr_count_d = wr_count_q + 16'd1;
               state_d    = S_HOLD;
               tmr_d      = TW'(HOLD_CYCLES - 1);
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_HOLD: begin
            if (tmr_q == '0) begin
               state_d = S_RECOVER;
               tmr_d   = TW'(RECOVER_CYCLES - 1);
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_RECOVER: begin
            // Gives the FIFO flag update time to cross the synchronizer before the next check.
            if (tmr_q == '0) begin
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            nwr_d   = 1'b1;
         end
      endcase

      wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      cmd_ready_d = (count_d != CW'(DEPTH));
      busy_d      = (count_d != '0) || (state_d != S_IDLE);
   end

   // State, control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         sync_q      <= 2'b11;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b0;
         fifo_d_q    <= 8'h00;
         nwr_q       <= 1'b1;
         busy_q      <= 1'b0;
         wr_count_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         sync_q      <= {sync_q[0], fifo_nff_in};
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
         fifo_d_q    <= fifo_d_d;
         nwr_q       <= nwr_d;
         busy_q      <= busy_d;
         wr_count_q  <= wr_count_d;
      end
   end

   // Queue storage: written on every accepted command byte.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; the pointers and count decide which entries are valid.
      if (push) begin
         mem_q[wr_ptr_q] <= cmd_data;
      end
   end

endmodule
